hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised scoreboard-based successor to the combinational hazard unit, for multi-cycle ops (mul/div, variable-latency loads).
//  Tracks every in-flight long-latency register write. Produces the ID-stage interlock and ID bypass selects.
//  Sits beside ID; issue info comes from the decoder, completions from the long-op units and data memory.
// PARAMETERS
//  REG_WIDTH    5   register index width; NUM_REGS = 2**REG_WIDTH, register 0 never tracked
//  LAT_WIDTH    4   fixed-latency counter width; latency 1..2**LAT_WIDTH-1, 0 = variable (memory)
//  MAX_PENDING  4   max simultaneously pending registers (2..NUM_REGS-1)
//  CNT_WIDTH    3   width of pending_count, >= clog2(MAX_PENDING+1)
// PORTS
//  clock          in   1          rising-edge clock
//  reset          in   1          synchronous, active-high
//  id_issue       in   1          ID holds a valid long-latency write op
//  id_flush       in   1          ID instruction squashed; suppresses issue this cycle
//  id_wr_reg      in   REG_WIDTH  destination of the issuing op
//  id_wr_lat      in   LAT_WIDTH  fixed latency; 0 = variable (completed via mem_done)
//  id_rs, id_rt   in   REG_WIDTH  source registers read in ID
//  id_rs_used     in   1          rs actually read
//  id_rt_used     in   1          rt actually read
//  mem_done       in   1          variable-latency result on the long writeback bus this cycle
//  mem_done_reg   in   REG_WIDTH  destination of that result
//  id_stall       out  1          hold IF/ID; bubble into EX
//  stall_cause    out  2          0 none, 1 RAW, 2 WAW/full, 3 writeback-port conflict
//  id_rs_fwd      out  1          take rs from the long writeback bus this cycle
//  id_rt_fwd      out  1          take rt from the long writeback bus this cycle
//  pending_vec    out  NUM_REGS   registered pending bits (bit 0 always 0)
//  pending_count  out  CNT_WIDTH  number of set pending bits
// BEHAVIOUR
//  State per register r: pend[r], cnt[r] (LAT_WIDTH), var[r]. Reset: all cleared.
//   After reset: id_stall=0, stall_cause=0, fwd=0, pending_vec=0, pending_count=0.
//  complete[r] (combinational) is true in either case:
//   - pend & !var & cnt==1
//   - pend & var & mem_done & mem_done_reg==r
//   mem_done for a non-pending or fixed register is ignored.
//  Each cycle, every pending fixed entry decrements cnt. An entry with complete[r] clears at the next edge.
//  RAW: a used source s != 0 with pend[s] & !complete[s]. Causes a stall.
//  Bypass: a used source with complete[s] sets its fwd bit, with no stall.
//  WAW/full: id_issue & id_wr_reg!=0 with either condition:
//   - pend[id_wr_reg] & !complete[id_wr_reg]
//   - (pending_count - completions this cycle) == MAX_PENDING
//  Port conflict: id_wr_lat!=0 & some pending fixed entry has cnt == id_wr_lat + 1.
//   One long writeback port exists, so two completions would land in the same cycle.
//  stall_cause priority: RAW > WAW/full > port. id_stall = (cause != 0) & !id_flush.
//  Issue accepted when id_issue & !id_stall & !id_flush & id_wr_reg!=0.
//   At the edge: pend=1, cnt=id_wr_lat, var=(id_wr_lat==0).
//   Issue to register 0 is a no-op and never stalls on WAW.
//  Same register completing and issuing in one cycle: the issue wins; the new state is written.
//  Flush: drops only the ID issue. In-flight entries keep counting and complete normally.
//  Latency: issue of lat L completes (bypass visible) L cycles after the issue edge.
//   A dependent op in ID stalls L-1 cycles, then proceeds with fwd=1.
//  pending_count and pending_vec are registered and reflect state after the last edge.
//  Reset asserted mid-operation clears all entries at that edge. Completions arriving during reset are dropped.
// TESTING
//  1 reset with id_issue=1 -> no pending bits set; all outputs 0 the cycle after reset drops.
//  2 issue r1 lat=3; next cycle rs=r1 used -> stall (cause 1) for 2 cycles.
//     On the 3rd cycle: id_stall=0, id_rs_fwd=1. pend[1] clears at the following edge.
//  3 issue r2 lat=0; rt=r2 used -> stall until mem_done=1 with mem_done_reg=2.
//     That cycle: id_rt_fwd=1, id_stall=0. mem_done_reg=5 earlier is ignored.
//  4 issue r3,r4,r5,r6 with lat=0 (MAX_PENDING=4); issue r7 -> stall cause 2.
//     mem_done for r4 that cycle -> r7 accepted; pending_count stays 4.
//  5 issue r1 lat=4; next cycle issue r2 lat=3 -> cause 3 stall.
//     Next cycle lat=3 is accepted. Re-issue to r1 before its completion -> cause 2.
//  6 RAW stall with id_flush=1 -> id_stall=0, no issue recorded. Issue to r0 -> pending_vec unchanged.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - scoreboard interlock for long-latency register writes
// Tracks pending writes, raises ID stalls (RAW, WAW/full, writeback-port conflict) and bypass selects.
module hazard_scoreboard #(
  parameter int REG_WIDTH   = 5,
  parameter int LAT_WIDTH   = 4,
  parameter int MAX_PENDING = 4,
  parameter int CNT_WIDTH   = 3,
  parameter int NUM_REGS    = 2 ** REG_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 id_issue,
  input  logic                 id_flush,
  input  logic [REG_WIDTH-1:0] id_wr_reg,
  input  logic [LAT_WIDTH-1:0] id_wr_lat,
  input  logic [REG_WIDTH-1:0] id_rs,
  input  logic [REG_WIDTH-1:0] id_rt,
  input  logic                 id_rs_used,
  input  logic                 id_rt_used,
  input  logic                 mem_done,
  input  logic [REG_WIDTH-1:0] mem_done_reg,
  output logic                 id_stall,
  output logic [1:0]           stall_cause,
  output logic                 id_rs_fwd,
  output logic                 id_rt_fwd,
  output logic [NUM_REGS-1:0]  pending_vec,
  output logic [CNT_WIDTH-1:0] pending_count
);

  logic [NUM_REGS-1:0]  pend_q, pend_d;
  logic [NUM_REGS-1:0]  var_q, var_d;
  logic [LAT_WIDTH-1:0] cnt_q [NUM_REGS];
  logic [LAT_WIDTH-1:0] cnt_d [NUM_REGS];
  logic [CNT_WIDTH-1:0] pending_count_q, pending_count_d;

  logic [NUM_REGS-1:0]  complete;
  logic [CNT_WIDTH-1:0] n_complete;
  logic [CNT_WIDTH-1:0] remaining;
  logic                 raw_hit, waw_hit, port_hit, accept;

  always_comb begin
    complete   = '0;
    n_complete = '0;
    port_hit   = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      complete[r] = pend_q[r] &&
                    ((!var_q[r] && cnt_q[r] == LAT_WIDTH'(1)) ||
                     (var_q[r] && mem_done && mem_done_reg == REG_WIDTH'(r)));
      n_complete  = n_complete + CNT_WIDTH'(complete[r]);
      // A new fixed op landing in the same cycle as an older one would need a second writeback port
      if (pend_q[r] && !var_q[r] &&
          ({1'b0, cnt_q[r]} == {1'b0, id_wr_lat} + (LAT_WIDTH+1)'(1)))
        port_hit = 1'b1;
    end
    port_hit  = port_hit && id_issue && id_wr_reg != '0 && id_wr_lat != '0;
    remaining = pending_count_q - n_complete;

    raw_hit = (id_rs_used && id_rs != '0 && pend_q[id_rs] && !complete[id_rs]) ||
              (id_rt_used && id_rt != '0 && pend_q[id_rt] && !complete[id_rt]);
    waw_hit = id_issue && id_wr_reg != '0 &&
              ((pend_q[id_wr_reg] && !complete[id_wr_reg]) ||
               remaining == CNT_WIDTH'(MAX_PENDING));

    id_rs_fwd = id_rs_used && complete[id_rs];
    id_rt_fwd = id_rt_used && complete[id_rt];

    stall_cause = 2'd0;
    if (raw_hit)       stall_cause = 2'd1;
    else if (waw_hit)  stall_cause = 2'd2;
    else if (port_hit) stall_cause = 2'd3;
    id_stall = (stall_cause != 2'd0) && !id_flush;
    accept   = id_issue && stall_cause == 2'd0 && !id_flush && id_wr_reg != '0;
  end

  always_comb begin
    pend_d          = pend_q;
    var_d           = var_q;
    pending_count_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      // Issue overrides a same-cycle completion of the same register
      if (accept && id_wr_reg == REG_WIDTH'(r)) begin
        pend_d[r] = 1'b1;
        cnt_d[r]  = id_wr_lat;
        var_d[r]  = (id_wr_lat == '0);
      end else if (complete[r]) begin
        pend_d[r] = 1'b0;
        cnt_d[r]  = '0;
        var_d[r]  = 1'b0;
      end else if (pend_q[r] && !var_q[r]) begin
        cnt_d[r]  = cnt_q[r] - LAT_WIDTH'(1);
      end
      pending_count_d = pending_count_d + CNT_WIDTH'(pend_d[r]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q          <= '0;
      var_q           <= '0;
      pending_count_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      pend_q          <= pend_d;
      var_q           <= var_d;
      pending_count_q <= pending_count_d;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign pending_vec   = pend_q;
  assign pending_count = pending_count_q;

endmodule
